seven_seg_scan: RTL and testbench

//  Time-multiplexed N-digit hex seven-segment scanner. Drives one shared active-low

---
 rtl/seven_seg_pkg.sv | 11 +
 rtl/seven_seg_scan_if.sv | 12 +
 rtl/seg7_decode.sv | 11 +
 rtl/seven_seg_scan.sv | 91 +++++++++
 tb/tb_seven_seg_scan.sv | 145 ++++++++++++++
 5 files changed

// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: shared constants and the active-low hex glyph table for the seven-segment scanner.
package seven_seg_pkg;
    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [6:0] GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        return GLYPH[nib];
    endfunction
endpackage

// File: rtl/seven_seg_scan_if.sv
// seven_seg_scan_if: display data in, segment/anode pins and frame pulse out.
interface seven_seg_scan_if #(parameter int N_DIGITS = 8);
    logic                  en;
    logic [4*N_DIGITS-1:0] value;
    logic [N_DIGITS-1:0]   dp_in;
    logic [N_DIGITS-1:0]   blank_in;
    logic [7:0]            seg;
    logic [N_DIGITS-1:0]   an;
    logic                  frame_done;
    modport master (output en, value, dp_in, blank_in, input seg, an, frame_done);
    modport slave  (input en, value, dp_in, blank_in, output seg, an, frame_done);
endinterface

// File: rtl/seg7_decode.sv
// seg7_decode: nibble + decimal point + blank -> active-low {dp,g,f,e,d,c,b,a}.
module seg7_decode
    import seven_seg_pkg::*;
(
    input  logic [3:0] i_nib,
    input  logic       i_dp,
    input  logic       i_blank,
    output logic [7:0] o_seg
);
    assign o_seg = i_blank ? SEG_OFF : {~i_dp, hex_to_seg(i_nib)};
endmodule

// File: rtl/seven_seg_scan.sv
// seven_seg_scan: time-multiplexed N-digit hex display scanner with per-frame data capture.
// Define SEVEN_SEG_LZB_EN to enable leading-zero blanking on the captured frame.
module seven_seg_scan
    import seven_seg_pkg::*;
#(
    parameter int N_DIGITS  = 8,
    parameter int TICK_DIV  = 100000,
    parameter int BLANK_CYC = 16
) (
    input logic clk,
    input logic rst,
    seven_seg_scan_if.slave bus
);
    localparam int CNT_W = $clog2(TICK_DIV);
    localparam int IDX_W = N_DIGITS > 1 ? $clog2(N_DIGITS) : 1;

    logic [CNT_W-1:0]      r_cnt;
    logic [IDX_W-1:0]      r_idx;
    logic [4*N_DIGITS-1:0] r_val;
    logic [N_DIGITS-1:0]   r_dp, r_blank, r_an;
    logic [7:0]            r_seg;
    logic                  r_fd;
    logic                  w_wrap, w_frame_end, w_dark, w_blank;
    logic [N_DIGITS-1:0]   w_lz;
    logic [7:0]            w_seg;

    assign w_wrap      = r_cnt == CNT_W'(TICK_DIV - 1);
    assign w_frame_end = w_wrap && r_idx == IDX_W'(N_DIGITS - 1);
    assign w_dark      = r_cnt < CNT_W'(BLANK_CYC);

`ifdef SEVEN_SEG_LZB_EN
    logic w_run;
    // Digit 0 is never suppressed, so the scan stops at index 1.
    always_comb begin
        w_lz  = '0;
        w_run = 1'b1;
        for (int i = N_DIGITS - 1; i > 0; i--) begin
            w_run   = w_run && r_val[4*i +: 4] == 4'd0;
            w_lz[i] = w_run;
        end
    end
`else
    assign w_lz = '0;
`endif

    assign w_blank = r_blank[r_idx] | w_lz[r_idx];

    seg7_decode u_dec (
        .i_nib   (r_val[4*r_idx +: 4]),
        .i_dp    (r_dp[r_idx]),
        .i_blank (w_blank),
        .o_seg   (w_seg)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_val   <= '0;
            r_dp    <= '0;
            r_blank <= '0;
            r_an    <= '1;
            r_seg   <= SEG_OFF;
            r_fd    <= 1'b0;
        end else if (!bus.en) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_val   <= bus.value;
            r_dp    <= bus.dp_in;
            r_blank <= bus.blank_in;
            r_an    <= '1;
            r_seg   <= SEG_OFF;
            r_fd    <= 1'b0;
        end else begin
            r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
            r_idx <= w_wrap ? (w_frame_end ? '0 : r_idx + 1'b1) : r_idx;
            if (w_frame_end) begin
                r_val   <= bus.value;
                r_dp    <= bus.dp_in;
                r_blank <= bus.blank_in;
            end
            r_an  <= w_dark ? '1 : ~(N_DIGITS'(1) << r_idx);
            r_seg <= w_dark ? SEG_OFF : w_seg;
            r_fd  <= w_frame_end;
        end
    end

    assign bus.an         = r_an;
    assign bus.seg        = r_seg;
    assign bus.frame_done = r_fd;
endmodule

// File: tb/tb_seven_seg_scan.sv
// tb_seven_seg_scan: scoreboard bench; a cycle-position model predicts every registered output.
module tb_seven_seg_scan;
    localparam int N = 4;
    localparam int T = 8;
    localparam int B = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    seven_seg_scan_if #(.N_DIGITS(N)) bus ();
    seven_seg_scan #(.N_DIGITS(N), .TICK_DIV(T), .BLANK_CYC(B)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    logic [7:0] gly [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    logic [12:0]  q [$];
    int           n_vec = 0;
    int           n_miss = 0;
    int           p, m_d, m_c;
    logic         m_fd;
    logic [3:0]   m_an;
    logic [7:0]   m_seg;
    logic [3:0]   sh_v [N];
    logic [N-1:0] sh_dp, sh_bl;
    logic [12:0]  e, got;

    function automatic logic [7:0] exp_seg(input int d);
        logic sup = 1'b0;
`ifdef SEVEN_SEG_LZB_EN
        sup = d != 0;
        for (int i = d; i < N; i++) if (sh_v[i] != 4'd0) sup = 1'b0;
`endif
        return (sh_bl[d] || sup) ? 8'hFF : {~sh_dp[d], gly[sh_v[d]][6:0]};
    endfunction

    task automatic load_shadow();
        for (int i = 0; i < N; i++) sh_v[i] = bus.value[4*i +: 4];
        sh_dp = bus.dp_in;
        sh_bl = bus.blank_in;
    endtask

    // Model: p counts enabled cycles since the scan (re)started.
    initial forever begin
        @(posedge clk);
        if (rst) begin
            p = 0;
            for (int i = 0; i < N; i++) sh_v[i] = 4'd0;
            sh_dp = '0;
            sh_bl = '0;
        end else if (!bus.en) begin
            q.push_back({4'hF, 8'hFF, 1'b0});
            p = 0;
            load_shadow();
        end else begin
            m_d   = (p / T) % N;
            m_c   = p % T;
            m_fd  = m_c == T - 1 && m_d == N - 1;
            m_an  = m_c >= B ? ~(4'b0001 << m_d) : 4'hF;
            m_seg = m_c >= B ? exp_seg(m_d) : 8'hFF;
            q.push_back({m_an, m_seg, m_fd});
            if (m_fd) load_shadow();
            p++;
        end
    end

    initial forever begin
        @(negedge clk or posedge rst);
        if (rst) begin
            #1;
            n_vec++;
            if ({bus.an, bus.seg, bus.frame_done} !== {4'hF, 8'hFF, 1'b0}) begin
                n_miss++;
                $display("FAIL reset: got an=%h seg=%h fd=%b, want an=f seg=ff fd=0",
                         bus.an, bus.seg, bus.frame_done);
            end
            q.delete();
        end else if (q.size() > 0) begin
            e   = q.pop_front();
            got = {bus.an, bus.seg, bus.frame_done};
            n_vec++;
            if (got !== e) begin
                n_miss++;
                $display("FAIL slot @%0t: got an=%h seg=%h fd=%b, want an=%h seg=%h fd=%b",
                         $time, got[12:9], got[8:1], got[0], e[12:9], e[8:1], e[0]);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_frame();
        for (int i = 0; i < 2 * N * T && !bus.frame_done; i++) @(negedge clk);
    endtask

    initial begin
        bus.en = 1'b1;
        bus.value = 16'h12AF;
        bus.dp_in = '0;
        bus.blank_in = '0;
        cycles(2);
        #1 rst = 1'b0;
        cycles(3 * N * T);
        bus.value = 16'h0000;
        cycles(2 * N * T);
        wait_frame();
        cycles(10);
        bus.value = 16'h8888;
        cycles(3 * N * T);
        bus.value = 16'h5555;
        bus.dp_in = 4'b0100;
        bus.blank_in = 4'b0001;
        cycles(2 * N * T);
        bus.dp_in = '0;
        bus.blank_in = '0;
        bus.value = 16'h0030;
        cycles(2 * N * T);
        bus.value = 16'h0000;
        cycles(2 * N * T);
        bus.value = 16'h0700;
        cycles(13);
        bus.en = 1'b0;
        cycles(3);
        bus.value = 16'h9C3E;
        cycles(2);
        bus.en = 1'b1;
        cycles(2 * N * T);
        cycles(11);
        @(negedge clk);
        #2 rst = 1'b1;
        cycles(2);
        #1 rst = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 39) == 0) bus.value = 16'($urandom);
            if ($urandom_range(0, 59) == 0) bus.dp_in = 4'($urandom);
            if ($urandom_range(0, 59) == 0) bus.blank_in = 4'($urandom);
            if ($urandom_range(0, 79) == 0) bus.value[15:8] = 8'h00;
            if ($urandom_range(0, 49) == 0) bus.en = ~bus.en;
        end
        cycles(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
